// File: rtl/seg_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_pkg
// Purpose  : Shared constants and types for the multiplexed 7-segment display.
//            Segment patterns are active-low, bit [7:1] = a..g, bit [0] = dp.
// Contents : segment constants (blank, 'P', dash), digit pattern lookup,
//            converter state enumeration.
// Revision : 1.0 - initial release
// ============================================================================
package seg_display_pkg;

  localparam logic [7:0] c_seg_blank = 8'hFF;
  localparam logic [7:0] c_seg_p     = 8'h31;
  localparam logic [7:0] c_seg_dash  = 8'hFD;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  // Decimal digit to active-low segment pattern; non-decimal codes blank.
  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    logic [7:0] pat;
    case (d)
      4'd0:    pat = 8'h03;
      4'd1:    pat = 8'h9F;
      4'd2:    pat = 8'h25;
      4'd3:    pat = 8'h0D;
      4'd4:    pat = 8'h99;
      4'd5:    pat = 8'h49;
      4'd6:    pat = 8'h41;
      4'd7:    pat = 8'h1F;
      4'd8:    pat = 8'h01;
      4'd9:    pat = 8'h09;
      default: pat = c_seg_blank;
    endcase
    return pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential double-dabble binary to BCD converter with a single
//            pending-request slot (latest request wins).
// Ports    : clk_i, rst_ni    - clock, asynchronous active-low reset
//            start_i, value_i - load strobe and binary value
//            busy_o           - conversion in progress (SHIFT or COMMIT)
//            done_o           - one-cycle strobe, bcd_o/ovf_o valid
//            bcd_o, ovf_o     - D BCD digits and sticky overflow
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import seg_display_pkg::*;
#(
  parameter int VALUE_W = 8,
  parameter int D       = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [VALUE_W-1:0] value_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [4*D-1:0]   bcd_o,
  output logic             ovf_o
);

  localparam int BCD_W = 4 * D;
  localparam int STEP_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam logic [STEP_W-1:0] c_last_step = STEP_W'(VALUE_W - 1);

  conv_state_e        state_q, state_d;
  logic [VALUE_W-1:0] sh_q, sh_d;
  logic [VALUE_W-1:0] pend_val_q, pend_val_d;
  logic               pend_q, pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   w_adj;
  logic               ovf_q, ovf_d;
  logic [STEP_W-1:0]  step_q, step_d;

  // Add-3 correction on every nibble that is 5 or more.
  always_comb begin
    w_adj = bcd_q;
    for (int i = 0; i < D; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    step_d     = step_q;
    done_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SHIFT;
          sh_d    = value_i;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          step_d  = '0;
        end
      end
      ST_SHIFT: begin
        // The adjusted MSB leaves the top digit here; a 1 means the value
        // cannot be represented in D digits.
        bcd_d  = {w_adj[BCD_W-2:0], sh_q[VALUE_W-1]};
        sh_d   = sh_q << 1;
        ovf_d  = ovf_q | w_adj[BCD_W-1];
        step_d = step_q + 1'b1;
        if (step_q == c_last_step) begin
          state_d = ST_COMMIT;
        end
        if (start_i) begin
          pend_d     = 1'b1;
          pend_val_d = value_i;
        end
      end
      ST_COMMIT: begin
        done_o = 1'b1;
        pend_d = 1'b0;
        if (start_i || pend_q) begin
          // A strobe in this very cycle is newer than the stored request.
          state_d = ST_SHIFT;
          sh_d    = start_i ? value_i : pend_val_q;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          step_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      step_q     <= step_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/seg_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_mux
// Purpose  : Time-multiplexed 7-segment driver. Digit 0 is a status digit
//            ('P' while paused), digits 1..NUM_DIGITS-1 show the last
//            committed value in decimal, MSD at digit 1.
// Ports    : clk_i, rst_ni     - clock, asynchronous active-low reset
//            value_i           - binary value, loaded on value_valid_i
//            paused_i          - status flag, shown live
//            blank_lz_i        - leading-zero blanking enable
//            sega_o            - digit enables, active-low, bit i = digit i
//            segd_o            - segments, active-low, [7:1]=a..g, [0]=dp
//            busy_o            - conversion in progress
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int REFRESH_HZ = 1000,
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [VALUE_W-1:0]    value_i,
  input  logic                  value_valid_i,
  input  logic                  paused_i,
  input  logic                  blank_lz_i,
  output logic [NUM_DIGITS-1:0] sega_o,
  output logic [7:0]            segd_o,
  output logic                  busy_o
);

  localparam int D     = NUM_DIGITS - 1;
  localparam int SLOT  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] c_slot_last = CNT_W'(SLOT - 1);
  localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [4*D-1:0]   disp_bcd_q, disp_bcd_d;
  logic             disp_ovf_q, disp_ovf_d;

  logic             w_conv_done;
  logic [4*D-1:0]   w_conv_bcd;
  logic             w_conv_ovf;
  logic [3:0]       w_dig;
  logic             w_run_zero;
  logic [7:0]       w_segd;

  bin2bcd_seq #(
    .VALUE_W (VALUE_W),
    .D       (D)
  ) u_conv (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (value_valid_i),
    .value_i (value_i),
    .busy_o  (busy_o),
    .done_o  (w_conv_done),
    .bcd_o   (w_conv_bcd),
    .ovf_o   (w_conv_ovf)
  );

  // Scan counter, digit index, and the committed display snapshot.
  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    disp_bcd_d = disp_bcd_q;
    disp_ovf_d = disp_ovf_q;
    if (cnt_q == c_slot_last) begin
      cnt_d = '0;
      idx_d = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
    end
    if (w_conv_done) begin
      disp_bcd_d = w_conv_bcd;
      disp_ovf_d = w_conv_ovf;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_bcd_q <= '0;
      disp_ovf_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_bcd_q <= disp_bcd_d;
      disp_ovf_q <= disp_ovf_d;
    end
  end

  // Digit select: first cycle of every slot is all-off so the segment
  // lines can settle before the next digit lights.
  always_comb begin
    sega_o = '1;
    if (cnt_q != '0) begin
      sega_o = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  // Segment decode. w_run_zero tracks whether every digit from the MSD down
  // to the current one is zero, which is exactly the leading-zero condition.
  always_comb begin
    w_segd     = c_seg_blank;
    w_dig      = '0;
    w_run_zero = 1'b1;
    if (idx_q == '0) begin
      w_segd = paused_i ? c_seg_p : c_seg_blank;
    end
    for (int k = 1; k <= D; k++) begin
      w_dig      = disp_bcd_q[4*(D-k) +: 4];
      w_run_zero = w_run_zero & (w_dig == 4'd0);
      if (idx_q == IDX_W'(k)) begin
        if (disp_ovf_q) begin
          w_segd = c_seg_dash;
        end else if (blank_lz_i && w_run_zero && (k != D)) begin
          w_segd = c_seg_blank;
        end else begin
          w_segd = seg_digit(w_dig);
        end
      end
    end
  end

  // Reset gates the segment lines directly so they are dark while held.
  assign segd_o = rst_ni ? w_segd : c_seg_blank;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_mux
// Purpose  : Directed self-checking bench for seg_display_mux. A 4-digit and
//            a 3-digit instance share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_mux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] value = '0;
  logic       valid = 1'b0;
  logic       paused = 1'b0;
  logic       blz = 1'b0;
  logic [3:0] sega4;
  logic [7:0] segd4;
  logic       busy4;
  logic [2:0] sega3;
  logic [7:0] segd3;
  logic       busy3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_display_mux #(
    .CLK_HZ(4000), .REFRESH_HZ(250), .NUM_DIGITS(4), .VALUE_W(8)
  ) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .value_i(value), .value_valid_i(valid),
    .paused_i(paused), .blank_lz_i(blz), .sega_o(sega4), .segd_o(segd4),
    .busy_o(busy4)
  );

  seg_display_mux #(
    .CLK_HZ(4000), .REFRESH_HZ(250), .NUM_DIGITS(3), .VALUE_W(8)
  ) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .value_i(value), .value_valid_i(valid),
    .paused_i(paused), .blank_lz_i(blz), .sega_o(sega3), .segd_o(segd3),
    .busy_o(busy3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seg_pat(input int d);
    case (d)
      0: return 8'h03; 1: return 8'h9F; 2: return 8'h25; 3: return 8'h0D;
      4: return 8'h99; 5: return 8'h49; 6: return 8'h41; 7: return 8'h1F;
      8: return 8'h01; 9: return 8'h09;
      default: return 8'hEE;
    endcase
  endfunction

  // Expected pattern on numeric digit k of an nd-digit display.
  function automatic logic [7:0] exp_num(input int val, input int nd, input int k, input bit lz);
    int dd, lim, p, hi;
    dd  = nd - 1;
    lim = 1;
    for (int i = 0; i < dd; i++) lim = lim * 10;
    if (val >= lim) return 8'hFD;
    p = 1;
    for (int i = 0; i < dd - k; i++) p = p * 10;
    hi = val / p;
    if (lz && (k < dd) && (hi == 0)) return 8'hFF;
    return seg_pat(hi % 10);
  endfunction

  // Waits for the first lit cycle of digit k (preceded by an all-off cycle).
  task automatic read_digit(input int nd, input int k, output logic [7:0] seg);
    logic [3:0] prev, cur, tgt;
    bit found;
    tgt   = ~(4'b0001 << k);
    prev  = 4'h0;
    found = 1'b0;
    seg   = 8'h00;
    for (int n = 0; n < 80 && !found; n++) begin
      @(negedge clk);
      cur = (nd == 4) ? sega4 : {1'b1, sega3};
      if (cur == tgt && prev == 4'hF) begin
        found = 1'b1;
        seg   = (nd == 4) ? segd4 : segd3;
      end
      prev = cur;
    end
    if (!found) check_eq("scan_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_display(input string tag, input int nd, input int val);
    logic [7:0] seg;
    for (int k = 1; k < nd; k++) begin
      read_digit(nd, k, seg);
      check_eq($sformatf("%s_d%0d", tag, k), {24'd0, seg}, {24'd0, exp_num(val, nd, k, blz)});
    end
  endtask

  task automatic load_value(input int v, output int busy_cycles);
    @(negedge clk);
    value = v[7:0];
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check_eq("busy3_match", {31'd0, busy3}, {31'd0, busy4});
    busy_cycles = 0;
    for (int n = 0; n < 40; n++) begin
      if (!busy4) break;
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int exp_val;
    logic [7:0] seg;

    // Reset state, with PAUSED high to confirm segments stay dark.
    paused = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_sega4", {28'd0, sega4}, 32'hF);
    check_eq("rst_segd4", {24'd0, segd4}, 32'hFF);
    check_eq("rst_busy4", {31'd0, busy4}, 32'd0);
    check_eq("rst_sega3", {29'd0, sega3}, 32'h7);
    paused = 1'b0;
    rst_n  = 1'b1;
    check_display("post_rst", 4, 0);

    // 200 then 45 three cycles later: BUSY 18 cycles, display 000->200->045.
    @(negedge clk);
    value = 8'd200;
    valid = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (j == 0) valid = 1'b0;
      if (j == 2) begin value = 8'd45; valid = 1'b1; end
      if (j == 3) valid = 1'b0;
      check_eq($sformatf("pend_busy_%0d", j), {31'd0, busy4}, {31'd0, (j <= 17)});
      exp_val = (j < 9) ? 0 : ((j < 18) ? 200 : 45);
      for (int k = 1; k < 4; k++) begin
        if (sega4 == ~(4'b0001 << k))
          check_eq($sformatf("pend_seg_%0d", j), {24'd0, segd4}, {24'd0, exp_num(exp_val, 4, k, 1'b0)});
      end
    end

    // 123 without blanking.
    load_value(123, bc);
    check_eq("busy_len_123", bc, 9);
    check_display("v123", 4, 123);

    // Leading-zero blanking.
    blz = 1'b1;
    load_value(7, bc);
    check_eq("busy_len_7", bc, 9);
    check_display("v7_lz", 4, 7);
    load_value(0, bc);
    check_display("v0_lz", 4, 0);

    // Status digit.
    paused = 1'b1;
    read_digit(4, 0, seg);
    check_eq("paused_on", {24'd0, seg}, 32'h31);
    paused = 1'b0;
    read_digit(4, 0, seg);
    check_eq("paused_off", {24'd0, seg}, 32'hFF);

    // 3-digit instance: overflow shows dash even with blanking on.
    load_value(100, bc);
    check_display("v100_n3", 3, 100);
    check_display("v100_n4", 4, 100);
    load_value(99, bc);
    check_display("v99_n3", 3, 99);
    load_value(255, bc);
    check_display("v255_n3", 3, 255);

    // Reset in the middle of a conversion.
    blz = 1'b0;
    load_value(5, bc);
    @(negedge clk);
    value = 8'd255;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_busy", {31'd0, busy4}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_sega4", {28'd0, sega4}, 32'hF);
    check_eq("async_segd4", {24'd0, segd4}, 32'hFF);
    check_eq("async_busy4", {31'd0, busy4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_display("abort_nolz", 4, 0);
    check_eq("abort_busy", {31'd0, busy4}, 32'd0);
    blz = 1'b1;
    check_display("abort_lz", 4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000: input clock frequency in Hz.
REQ-002 SHALL have parameter REFRESH_HZ, default 1000: full-scan rate in Hz, covering all digits.
REQ-003 SHALL have parameter NUM_DIGITS, default 4, minimum 2: number of display digits; digit 0 is the status digit, digits 1..NUM_DIGITS-1 are numeric (D = NUM_DIGITS-1).
REQ-004 SHALL have parameter VALUE_W, default 8: width of the binary input value.
REQ-005 SHALL have ports: CLK input 1 (system clock); RST_N input 1 (reset); VALUE input VALUE_W (binary value); VALUE_VALID input 1 (load strobe); PAUSED input 1 (status flag); BLANK_LZ input 1 (leading-zero blanking enable); SEGA output NUM_DIGITS (digit select, active-low, bit i = digit i); SEGD output 8 (segments, active-low, [7:1]=a..g, [0]=dp); BUSY output 1 (conversion in progress).
REQ-006 SHALL use one clock, CLK; reset is asynchronous and active-low, RST_N.

Function
REQ-007 SHALL derive SLOT = CLK_HZ/(REFRESH_HZ*NUM_DIGITS) cycles per digit slot, using a counter from 0 to SLOT-1 that wraps.
REQ-008 SHALL advance the digit index on counter wrap, 0..NUM_DIGITS-1, wrapping to 0.
REQ-009 SHALL drive SEGA all ones on counter value 0 of every slot (anti-ghost gap) and ~(1<<index) on the remaining SLOT-1 cycles.
REQ-010 SHALL hold SEGD[0]=1 (dp off) at all times.
REQ-011 Status digit SHALL show 'P' (SEGD=8'h31) when PAUSED=1 and blank (8'hFF) when PAUSED=0, sampled live.
REQ-012 Numeric digit k (1..D) SHALL show committed BCD digit D-k, so the most significant digit is at index 1; patterns: 0=03,1=9F,2=25,3=0D,4=99,5=49,6=41,7=1F,8=01,9=09 (hex).
REQ-013 With BLANK_LZ=1, zero digits left of the first nonzero digit SHALL show blank; the least significant digit always shows.
REQ-014 SHALL, when the committed value exceeds 10^D-1, show dash (8'hFD) on all numeric digits regardless of BLANK_LZ.
REQ-015 Converter states SHALL be IDLE, SHIFT and COMMIT.
REQ-016 IDLE->SHIFT: VALUE_VALID=1 sampled at edge k latches VALUE; BUSY=1 from k+1.
REQ-017 SHIFT SHALL run double-dabble (add-3 when a nibble >=5, then shift) for exactly VALUE_W cycles and set a sticky overflow if a nonzero bit shifts out of digit D-1.
REQ-018 COMMIT SHALL occur at cycle k+VALUE_W+1 and atomically update the display BCD register and overflow flag; BUSY=0 from the next cycle; COMMIT->IDLE, or ->SHIFT if pending.
REQ-019 VALUE_VALID while BUSY SHALL overwrite a single pending register (latest wins) and start a new conversion immediately after COMMIT; the display never shows a partial conversion.
REQ-020 VALUE_VALID in the COMMIT cycle SHALL be treated as pending.

Reset
REQ-021 While RST_N=0: SEGA all ones, SEGD=8'hFF, BUSY=0, state IDLE, pending cleared, BCD register 0, overflow 0, counter 0, index 0.
REQ-022 Reset during SHIFT SHALL abort the conversion; after release the display shows a single '0' (BLANK_LZ=1) or all zeros (BLANK_LZ=0).

Structure
REQ-023 Package seg_display_pkg SHALL hold the segment pattern constants (digits, P, dash, blank) and the converter state enum.
REQ-024 Sequential converter SHALL be sub-module bin2bcd_seq (parameters VALUE_W and D; ports start, value, busy, done, bcd, ovf); scan and decode stay in seg_display_mux.

Verification
Bench parameters: CLK_HZ=4000, REFRESH_HZ=250, NUM_DIGITS=4, VALUE_W=8, giving SLOT=4.
REQ-025 Load 123 with BLANK_LZ=0 -> BUSY high for 9 cycles; then slots 1/2/3 show 9F/25/0D, each preceded by one all-off cycle.
REQ-026 Load 7 with BLANK_LZ=1 -> digits 1,2 = FF; digit 3 = 1F; load 0 -> FF,FF,03.
REQ-027 Set PAUSED=1 -> status slot shows SEGA=4'b1110, SEGD=8'h31; PAUSED=0 -> SEGD=8'hFF.
REQ-028 Load 200 then 45 three cycles later -> display goes 000->200->045 (BLANK_LZ=0); never shows an intermediate value; BUSY high continuously for 18 cycles.
REQ-029 NUM_DIGITS=3, load 100 -> both numeric digits FD; load 99 -> 09,09.
REQ-030 Assert RST_N=0 mid-SHIFT of 255 -> outputs go to reset values asynchronously; after release the display shows 000 and BUSY=0.
